// File: rtl/fnd_pkg.sv
// Shared constants, load-FSM state type and the leading-zero blanking helper
// for the 4-digit FND scan controller.
package fnd_pkg;

  localparam int                 FND_DIGITS = 4;
  localparam int                 VALUE_W    = 14;
  localparam int                 BCD_W      = 4 * FND_DIGITS;
  localparam logic [VALUE_W-1:0] BCD_MAX    = 14'd9999;
  localparam logic [3:0]         DIGIT_ERR  = 4'ha;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    COMMIT
  } load_state_e;

  // Slot idx is blanked when it and every more significant digit are zero;
  // the ones digit is never blanked so a value of 0 still shows "0".
  function automatic logic lead_blank(input logic [BCD_W-1:0] bcd,
                                      input logic [1:0]       idx);
    logic zero;
    zero = (idx != 2'd0);
    for (int i = 0; i < FND_DIGITS; i++) begin
      if (i >= int'(idx) && bcd[4*i +: 4] != 4'd0) zero = 1'b0;
    end
    return zero;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative shift-add-3 binary to BCD converter: one bit per cycle, VALUE_W
// cycles per conversion. o_done is high during the final step cycle.
module bin2bcd_seq
  import fnd_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [VALUE_W-1:0] i_value,
  output logic               o_done,
  output logic [BCD_W-1:0]   o_bcd
);

  logic [VALUE_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic [BCD_W-1:0]   adj;

  always_comb begin
    bin_d  = bin_q;
    bcd_d  = bcd_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    adj    = bcd_q;
    for (int i = 0; i < FND_DIGITS; i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
    if (i_start) begin
      bin_d  = i_value;
      bcd_d  = '0;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      {bcd_d, bin_d} = {adj, bin_q} << 1;
      cnt_d = cnt_q + 4'd1;
      if (cnt_q == 4'(VALUE_W - 1)) busy_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      bcd_q  <= bcd_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign o_done = busy_q && (cnt_q == 4'(VALUE_W - 1));
  assign o_bcd  = bcd_q;

endmodule

// File: rtl/fnd_scan_ctrl.sv
// 4-digit FND sequencing controller: load handshake + BCD conversion into a
// display register, and a free-running digit scan driving decoder and commons.
//
//   state  | meaning
//   IDLE   | o_ready=1, waiting for i_valid
//   CONV   | converter running, 14 shift-add-3 steps
//   COMMIT | result copied into display register this cycle
module fnd_scan_ctrl
  import fnd_pkg::*;
#(
  parameter int P_CLK_DIV = 100_000
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_valid,
  input  logic [VALUE_W-1:0] i_value,
  input  logic               i_lzb,
  output logic               o_ready,
  output logic [3:0]         o_digit,
  output logic               o_blank,
  output logic [3:0]         o_fndCom
);

  localparam int PW = (P_CLK_DIV > 1) ? $clog2(P_CLK_DIV) : 1;

  load_state_e      state_q, state_d;
  logic             lzb_pend_q, lzb_pend_d;
  logic             ovf_pend_q, ovf_pend_d;
  logic [BCD_W-1:0] disp_bcd_q, disp_bcd_d;
  logic             disp_lzb_q, disp_lzb_d;
  logic             disp_ovf_q, disp_ovf_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       com_q, com_d;
  logic [3:0]       digit_q, digit_d;
  logic             blank_q, blank_d;
  logic             conv_start;
  logic             conv_done;
  logic [BCD_W-1:0] conv_bcd;
  logic             tc;

  bin2bcd_seq u_bin2bcd (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_start (conv_start),
    .i_value (i_value),
    .o_done  (conv_done),
    .o_bcd   (conv_bcd)
  );

  always_comb begin
    state_d    = state_q;
    lzb_pend_d = lzb_pend_q;
    ovf_pend_d = ovf_pend_q;
    disp_bcd_d = disp_bcd_q;
    disp_lzb_d = disp_lzb_q;
    disp_ovf_d = disp_ovf_q;
    conv_start = 1'b0;
    o_ready    = (state_q == IDLE);
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          conv_start = 1'b1;
          lzb_pend_d = i_lzb;
          ovf_pend_d = (i_value > BCD_MAX);
          state_d    = CONV;
        end
      end
      CONV: begin
        if (conv_done) state_d = COMMIT;
      end
      COMMIT: begin
        disp_bcd_d = conv_bcd;
        disp_lzb_d = lzb_pend_q;
        disp_ovf_d = ovf_pend_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Scan path runs regardless of the load FSM; outputs are registered together
  // so digit and common never disagree.
  always_comb begin
    tc      = (presc_q == PW'(P_CLK_DIV - 1));
    presc_d = tc ? '0 : presc_q + 1'b1;
    idx_d   = tc ? idx_q + 2'd1 : idx_q;
    com_d   = ~(4'b0001 << idx_q);
    if (disp_ovf_q) begin
      digit_d = DIGIT_ERR;
      blank_d = 1'b0;
    end else begin
      digit_d = disp_bcd_q[{idx_q, 2'b00} +: 4];
      blank_d = disp_lzb_q && lead_blank(disp_bcd_q, idx_q);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= IDLE;
      lzb_pend_q <= 1'b0;
      ovf_pend_q <= 1'b0;
      disp_bcd_q <= '0;
      disp_lzb_q <= 1'b0;
      disp_ovf_q <= 1'b0;
      presc_q    <= '0;
      idx_q      <= 2'd0;
      com_q      <= 4'b1110;
      digit_q    <= 4'h0;
      blank_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      lzb_pend_q <= lzb_pend_d;
      ovf_pend_q <= ovf_pend_d;
      disp_bcd_q <= disp_bcd_d;
      disp_lzb_q <= disp_lzb_d;
      disp_ovf_q <= disp_ovf_d;
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      com_q      <= com_d;
      digit_q    <= digit_d;
      blank_q    <= blank_d;
    end
  end

  assign o_fndCom = com_q;
  assign o_digit  = digit_q;
  assign o_blank  = blank_q;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Self-checking bench for fnd_scan_ctrl with P_CLK_DIV=4: table of loads with
// expected slot contents, a slot scoreboard queue, and hand-written corner cases.
module tb_fnd_scan_ctrl;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [13:0] value;
  logic        lzb;
  logic        ready;
  logic [3:0]  digit;
  logic        blank;
  logic [3:0]  com;

  always #5 clk = ~clk;

  fnd_scan_ctrl #(.P_CLK_DIV(DIV)) dut (
    .i_clk    (clk),
    .i_reset  (rst),
    .i_valid  (valid),
    .i_value  (value),
    .i_lzb    (lzb),
    .o_ready  (ready),
    .o_digit  (digit),
    .o_blank  (blank),
    .o_fndCom (com)
  );

  typedef struct {
    logic [3:0] com;
    logic [3:0] digit;
    logic       blank;
  } slot_t;

  typedef struct {
    logic [13:0] value;
    logic        lzb;
    logic [15:0] exp_bcd;
    logic [3:0]  exp_blank;
  } vec_t;

  slot_t sb_q[$];
  vec_t  vecs[12];
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] bcd_of(input int v);
    logic [15:0] r;
    int          x;
    x = v;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic push_frame(input logic [15:0] bcd, input logic [3:0] bmask);
    slot_t      e;
    logic [3:0] one;
    for (int s = 0; s < 4; s++) begin
      one     = 4'b0001;
      e.com   = ~(one << s);
      e.digit = bcd[4*s +: 4];
      e.blank = bmask[s];
      sb_q.push_back(e);
    end
  endtask

  // Called at a negedge; finds slot 0 and then samples one cycle per slot.
  task automatic check_frame(input string name);
    slot_t e;
    bit    found;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (com == 4'b1110) found = 1'b1;
      else @(negedge clk);
    end
    check({name, "_slot0_seen"}, int'(found), 1);
    for (int s = 0; s < 4; s++) begin
      e = sb_q.pop_front();
      if (found) begin
        check($sformatf("%s_com%0d", name, s), int'(com), int'(e.com));
        check($sformatf("%s_digit%0d", name, s), int'(digit), int'(e.digit));
        check($sformatf("%s_blank%0d", name, s), int'(blank), int'(e.blank));
      end
      repeat (DIV) @(negedge clk);
    end
  endtask

  // Entered at a negedge with the DUT idle; returns after the edge where the
  // committed data becomes visible on the outputs.
  task automatic do_load(input logic [13:0] v, input logic l, output int busy);
    valid = 1'b1;
    value = v;
    lzb   = l;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    busy  = 0;
    while (ready == 1'b0 && busy < 40) begin
      busy++;
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] prev;
    int         run, ntr, busy;
    bit         seen;
    logic [15:0] exp;

    vecs[0]  = '{14'd1234,  1'b0, 16'h1234, 4'b0000};
    vecs[1]  = '{14'd42,    1'b1, 16'h0042, 4'b1100};
    vecs[2]  = '{14'd0,     1'b1, 16'h0000, 4'b1110};
    vecs[3]  = '{14'd12000, 1'b0, 16'haaaa, 4'b0000};
    vecs[4]  = '{14'd9999,  1'b0, 16'h9999, 4'b0000};
    vecs[5]  = '{14'd1005,  1'b1, 16'h1005, 4'b0000};
    vecs[6]  = '{14'd70,    1'b1, 16'h0070, 4'b1100};
    vecs[7]  = '{14'd300,   1'b1, 16'h0300, 4'b1000};
    vecs[8]  = '{14'd10000, 1'b1, 16'haaaa, 4'b0000};
    vecs[9]  = '{14'd8,     1'b0, 16'h0008, 4'b0000};
    vecs[10] = '{14'd16383, 1'b1, 16'haaaa, 4'b0000};
    vecs[11] = '{14'd9999,  1'b1, 16'h9999, 4'b0000};

    rst   = 1'b1;
    valid = 1'b0;
    value = '0;
    lzb   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", int'(ready), 1);
    check("rst_com", int'(com), 'he);
    check("rst_digit", int'(digit), 0);
    check("rst_blank", int'(blank), 0);
    rst = 1'b0;

    // Free-running scan after reset: rotation order and 4-cycle slots.
    prev = com;
    run  = 1;
    ntr  = 0;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (com == prev) begin
        run++;
      end else begin
        check("scan_order", int'(com), int'({prev[2:0], prev[3]}));
        if (seen) check("scan_hold", run, DIV);
        check("scan_digit", int'(digit), 0);
        check("scan_blank", int'(blank), 0);
        seen = 1'b1;
        ntr++;
        run  = 1;
        prev = com;
      end
    end
    check("scan_transitions", int'(ntr >= 8), 1);

    foreach (vecs[i]) begin
      do_load(vecs[i].value, vecs[i].lzb, busy);
      check($sformatf("busy_len_%0d", vecs[i].value), busy, 15);
      push_frame(vecs[i].exp_bcd, vecs[i].exp_blank);
      check_frame($sformatf("load_%0d", vecs[i].value));
    end

    // i_valid held high with a changing value: accepts at t=0 and t=16 only.
    lzb   = 1'b0;
    valid = 1'b1;
    for (int t = 0; t <= 20; t++) begin
      value = 14'(1000 + 3 * t);
      if (t == 0 || t == 16) check($sformatf("stream_ready_t%0d", t), int'(ready), 1);
      if (t == 1 || t == 15) check($sformatf("stream_ready_t%0d", t), int'(ready), 0);
      @(posedge clk);
      @(negedge clk);
    end
    valid = 1'b0;
    repeat (16) @(negedge clk);
    check("stream_idle", int'(ready), 1);
    exp = bcd_of(1000 + 3 * 16);
    push_frame(exp, 4'b0000);
    check_frame("stream");

    // Reset during CONV cycle 7 of a load of 5678: nothing is committed.
    valid = 1'b1;
    value = 14'd5678;
    lzb   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    repeat (6) @(negedge clk);
    check("midconv_busy", int'(ready), 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_ready", int'(ready), 1);
    check("midrst_com", int'(com), 'he);
    check("midrst_digit", int'(digit), 0);
    check("midrst_blank", int'(blank), 0);
    repeat (20) @(negedge clk);
    check("midrst_still_idle", int'(ready), 1);
    push_frame(16'h0000, 4'b0000);
    check_frame("midrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
